// File: rtl/dcache_sram0.sv
// dcache_sram0: simple dual-port SRAM, data array for D-cache way 0.
// One write port with byte enables and one always-on read port with
// registered output. An optional second output register adds a cycle
// of latency. Storage is never reset; only the read output path is.
module dcache_sram0 #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = 4,
   parameter int BYTE_SIZE  = 8,
   parameter int OUTPUT_REG = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [BE_WIDTH-1:0]   wr_byte_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Combinational read of the addressed word, assembled from the lanes
   logic [DATA_WIDTH-1:0] rd_word;
   // First read register, always present
   logic [DATA_WIDTH-1:0] rd_q;

   // Each byte lane owns its own storage array, so a lane write never
   // touches neighbouring lanes and no read-modify-write is needed.
   for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
      logic [BYTE_SIZE-1:0] mem [DEPTH];

      // Lane write; storage deliberately has no reset
      always_ff @(posedge clk) begin
         if (wr_en && wr_byte_en[i])
            mem[wr_addr] <= wr_data[i*BYTE_SIZE +: BYTE_SIZE];
      end

      assign rd_word[i*BYTE_SIZE +: BYTE_SIZE] = mem[rd_addr];
   end

   // Read capture every edge; non-blocking write above makes this read-first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= rd_word;
   end

   if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] rd_pipe;

      // Extra output stage, cleared together with the first register
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) rd_pipe <= '0;
         else        rd_pipe <= rd_q;
      end

      assign rd_data = rd_pipe;
   end else begin : g_noreg
      assign rd_data = rd_q;
   end

endmodule

// File: tb/tb_dcache_sram0.sv
// tb_dcache_sram0: drives a latency-1 and a latency-2 build with the same
// stimulus and compares both against a word-level memory model.
module tb_dcache_sram0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [8:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_byte_en = '0;
   logic [8:0]  rd_addr = '0;
   logic [31:0] rd0, rd1;

   int checks = 0;
   int errors = 0;

   // Reference model: word array plus "fully written" flag per word
   logic [31:0] mem_m [512];
   bit          known [512];
   // Expected outputs of the latency-1 (e0) and latency-2 (e1) builds
   logic [31:0] e0 = '0, e1 = '0;
   bit          e0v = 1'b1, e1v = 1'b1;

   always #5 clk = ~clk;

   dcache_sram0 #(.OUTPUT_REG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_byte_en(wr_byte_en), .rd_addr(rd_addr),
      .rd_data(rd0));

   dcache_sram0 #(.OUTPUT_REG(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_byte_en(wr_byte_en), .rd_addr(rd_addr),
      .rd_data(rd1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // One clock cycle: inputs driven at the falling edge, outputs checked at
   // the next falling edge against what the model predicts.
   task automatic cyc(input bit we, input logic [8:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic [8:0] ra, input string tag);
      logic [31:0] w;
      wr_en = we; wr_addr = wa; wr_data = wd; wr_byte_en = be; rd_addr = ra;
      @(posedge clk);
      // Read sees the contents from before this edge's write
      e1 = e0; e1v = e0v;
      e0 = mem_m[ra]; e0v = known[ra];
      if (we) begin
         w = mem_m[wa];
         for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
         mem_m[wa] = w;
         if (be == 4'hF) known[wa] = 1'b1;
      end
      @(negedge clk);
      if (e0v) chk({tag, "_lat1"}, rd0, e0);
      if (e1v) chk({tag, "_lat2"}, rd1, e1);
   endtask

   initial begin
      for (int a = 0; a < 512; a++) begin
         mem_m[a] = '0;
         known[a] = 1'b0;
      end

      // Reset held for 200 ns: outputs stay zero
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("reset_lat1", rd0, 32'h0);
         chk("reset_lat2", rd1, 32'h0);
      end
      rst_n = 1'b1;

      // Full sweep writes, decrementing data
      for (int a = 0; a < 512; a++)
         cyc(1'b1, 9'(a), 32'hFFFF_FFFF - 32'(a), 4'hF, 9'(a), "sweep_wr");
      // Full sweep reads, consecutive addresses
      for (int a = 0; a < 512; a++)
         cyc(1'b0, '0, '0, 4'h0, 9'(a), "sweep_rd");
      cyc(1'b0, '0, '0, 4'h0, 9'd0, "sweep_rd");
      chk("sweep_last", rd1, 32'hFFFF_FFFF - 32'd511);

      // Byte-enable merge
      cyc(1'b1, 9'd5, 32'h1122_3344, 4'hF, 9'd0, "be_wr1");
      cyc(1'b1, 9'd5, 32'hAABB_CCDD, 4'h5, 9'd0, "be_wr2");
      cyc(1'b1, 9'd6, 32'h5555_5555, 4'h0, 9'd5, "be_rd");
      chk("be_const", rd0, 32'h11BB_33DD);
      cyc(1'b0, 9'd5, 32'h0, 4'hF, 9'd6, "be_none");
      chk("be_zero_en", rd0, 32'hFFFF_FFFF - 32'd6);

      // Read-during-write on the same address returns old data
      cyc(1'b1, 9'd7, 32'h0000_0001, 4'hF, 9'd0, "rdw_init");
      cyc(1'b1, 9'd7, 32'h1234_5678, 4'hF, 9'd7, "rdw_same");
      chk("rdw_old", rd0, 32'h0000_0001);
      cyc(1'b0, '0, '0, 4'h0, 9'd7, "rdw_next");
      chk("rdw_new", rd0, 32'h1234_5678);

      // Asynchronous reset between edges while a non-zero word is held
      #2 rst_n = 1'b0;
      #1;
      chk("arst_lat1", rd0, 32'h0);
      chk("arst_lat2", rd1, 32'h0);
      e0 = '0; e1 = '0; e0v = 1'b1; e1v = 1'b1;
      #1 rst_n = 1'b1;
      cyc(1'b0, '0, '0, 4'h0, 9'd7, "arst_rd1");
      chk("arst_kept", rd0, 32'h1234_5678);
      cyc(1'b0, '0, '0, 4'h0, 9'd7, "arst_rd2");

      // Random traffic, reads biased toward the write address
      for (int k = 0; k < 600; k++) begin
         logic [8:0] wa, ra;
         wa = 9'($urandom_range(0, 511));
         ra = ($urandom_range(0, 3) == 0) ? wa : 9'($urandom_range(0, 511));
         cyc(1'($urandom), wa, $urandom, 4'($urandom), ra, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
